// File: rtl/demux_frame_if.sv
// Bit-serial demux bus: interleaved input line plus recovered channel bytes and status pulses.
interface demux_frame_if;
    logic       b;
    logic       b_valid;
    logic       sync;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       b_out_valid;
    logic       abort;
    logic       busy;
    logic       parity_err;

    modport master (
        output b, b_valid, sync,
        input  b0, b1, b_out_valid, abort, busy, parity_err
    );

    modport slave (
        input  b, b_valid, sync,
        output b0, b1, b_out_valid, abort, busy, parity_err
    );
endinterface

// File: rtl/demux_frame.sv
// Splits an interleaved ch0/ch1 bit stream into two bytes per sync-delimited frame.
// Optional trailing even-parity beat is enabled with `DEMUX_PARITY_EN.
module demux_frame (
    input  logic         clk,
    input  logic         rst,
    demux_frame_if.slave bus
);
    localparam int unsigned KW = 5;
    localparam int unsigned DW = 8;
`ifdef DEMUX_PARITY_EN
    localparam logic [KW-1:0] K_PARITY = KW'(2 * DW);
`else
    localparam logic [KW-1:0] K_LAST_DATA = KW'(2 * DW - 1);
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [DW-1:0]   r_sr0;
    logic [DW-1:0]   r_sr1;
    logic [DW-1:0]   r_b0;
    logic [DW-1:0]   r_b1;
    logic            r_out_valid;
    logic            r_abort;
`ifdef DEMUX_PARITY_EN
    logic            r_parity_err;
    logic            w_parity_ok;
`else
    logic            w_last_data;
`endif
    logic [DW-1:0]   w_sr0_shift;
    logic [DW-1:0]   w_sr1_shift;
    logic            w_start;

    // LSB-first: new bit enters at the MSB so the first bit ends up in bit 0.
    assign w_sr0_shift = {bus.b, r_sr0[DW-1:1]};
    assign w_sr1_shift = {bus.b, r_sr1[DW-1:1]};
    assign w_start     = bus.b_valid & bus.sync;
`ifdef DEMUX_PARITY_EN
    assign w_parity_ok = ((^{r_sr0, r_sr1}) == bus.b);
`else
    assign w_last_data = (r_k == K_LAST_DATA);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_sr0       <= '0;
            r_sr1       <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_out_valid <= 1'b0;
            r_abort     <= 1'b0;
`ifdef DEMUX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            r_abort     <= 1'b0;
`ifdef DEMUX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (w_start) begin
                // A sync beat is always beat 0; in RUN it discards the frame in progress.
                r_abort <= (r_state == S_RUN);
                r_state <= S_RUN;
                r_k     <= KW'(1);
                r_sr0   <= w_sr0_shift;
            end else if (bus.b_valid && (r_state == S_RUN)) begin
`ifdef DEMUX_PARITY_EN
                if (r_k == K_PARITY) begin
                    if (w_parity_ok) begin
                        r_b0        <= r_sr0;
                        r_b1        <= r_sr1;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_parity_err <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_k     <= '0;
                end else
`endif
                begin
                    if (r_k[0]) begin
                        r_sr1 <= w_sr1_shift;
                    end else begin
                        r_sr0 <= w_sr0_shift;
                    end
                    r_k <= r_k + KW'(1);
`ifndef DEMUX_PARITY_EN
                    // Last data beat is always ch1, so publish its shifted value directly.
                    if (w_last_data) begin
                        r_b0        <= r_sr0;
                        r_b1        <= w_sr1_shift;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                        r_k         <= '0;
                    end
`endif
                end
            end
        end
    end

    assign bus.b0          = r_b0;
    assign bus.b1          = r_b1;
    assign bus.b_out_valid = r_out_valid;
    assign bus.abort       = r_abort;
    assign bus.busy        = (r_state == S_RUN);
`ifdef DEMUX_PARITY_EN
    assign bus.parity_err  = r_parity_err;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_demux_frame.sv
// Self-checking bench for demux_frame: per-scenario tasks against a frame-level model.
module tb_demux_frame;
`ifdef DEMUX_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_frame_if u_if();
    demux_frame u_dut (.clk(clk), .rst(rst), .bus(u_if));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         v_cyc[$];
    logic [7:0] v_b0[$];
    logic [7:0] v_b1[$];
    int         a_cyc[$];
    logic [15:0] a_out[$];
    int         p_cyc[$];

    // Pulse recorder: every output pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (u_if.b_out_valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_b0.push_back(u_if.b0);
            v_b1.push_back(u_if.b1);
        end
        if (u_if.abort === 1'b1) begin
            a_cyc.push_back(cyc);
            a_out.push_back({u_if.b0, u_if.b1});
        end
        if (u_if.parity_err === 1'b1) p_cyc.push_back(cyc);
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_b0 = 8'h00;
    logic [7:0] exp_b1 = 8'h00;

    // Beat k of a frame: even -> ch0, odd -> ch1, bit k/2; beat 16 is even parity.
    function automatic logic beat_bit(input logic [7:0] c0, input logic [7:0] c1,
                                      input int k, input bit bad);
        logic [15:0] d;
        d = {c1, c0};
        if (k == 16) return (^d) ^ bad;
        return (k % 2 == 1) ? c1[k / 2] : c0[k / 2];
    endfunction

    task automatic step(input logic bv, input logic s, input logic bb, input logic r);
        @(negedge clk);
        u_if.b_valid = bv;
        u_if.sync    = s;
        u_if.b       = bb;
        rst          = r;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic flush;
        @(posedge clk);
        v_cyc.delete(); v_b0.delete(); v_b1.delete();
        a_cyc.delete(); a_out.delete(); p_cyc.delete();
    endtask

    task automatic send_frame(input logic [7:0] c0, input logic [7:0] c1, input bit bad,
                              input int nbeats, input int st_a, input int st_b, input int st_len,
                              output int first_c, output int last_c);
        first_c = 0;
        last_c  = 0;
        for (int k = 0; k < nbeats; k++) begin
            step(1'b1, 1'(k == 0), beat_bit(c0, c1, k, bad), 1'b0);
            if (k == 0) first_c = cyc + 1;
            last_c = cyc + 1;
            if (k == st_a || k == st_b) idle(st_len);
        end
    endtask

    task automatic test_reset;
        u_if.b_valid = 1'b0; u_if.sync = 1'b0; u_if.b = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({u_if.b0, u_if.b1} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bytes: got %h want 0000", {u_if.b0, u_if.b1});
        end
        n_tests++;
        if ({u_if.b_out_valid, u_if.abort, u_if.busy, u_if.parity_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {u_if.b_out_valid, u_if.abort, u_if.busy, u_if.parity_err});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_frame;
        int f, l;
        flush();
        send_frame(8'hA5, 8'h3C, 1'b0, NB, -1, -1, 0, f, l);
        idle(3);
        n_tests++;
        if (v_cyc.size() !== 1) begin
            n_fail++; $display("FAIL frame_count: got %0d want 1", v_cyc.size());
        end else if (v_cyc[0] !== l || v_b0[0] !== 8'hA5 || v_b1[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL frame_data: got cyc %0d %h/%h want cyc %0d A5/3C", v_cyc[0], v_b0[0], v_b1[0], l);
        end
        n_tests++;
        if (a_cyc.size() !== 0 || p_cyc.size() !== 0 || u_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_flags: got abort %0d perr %0d busy %b want 0 0 0",
                     a_cyc.size(), p_cyc.size(), u_if.busy);
        end
        exp_b0 = 8'hA5; exp_b1 = 8'h3C;
    endtask

    task automatic test_stall;
        int f, l;
        flush();
        send_frame(8'hA5, 8'h3C, 1'b0, NB, 4, 11, 3, f, l);
        idle(3);
        n_tests++;
        if (l - f !== NB - 1 + 6) begin
            n_fail++; $display("FAIL stall_span: got %0d want %0d", l - f, NB - 1 + 6);
        end
        n_tests++;
        if (v_cyc.size() !== 1) begin
            n_fail++; $display("FAIL stall_count: got %0d want 1", v_cyc.size());
        end else if (v_cyc[0] !== l || v_b0[0] !== 8'hA5 || v_b1[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL stall_data: got cyc %0d %h/%h want cyc %0d A5/3C", v_cyc[0], v_b0[0], v_b1[0], l);
        end
    endtask

    task automatic test_random;
        int f, l;
        logic [7:0] c0, c1;
        for (int i = 0; i < 6; i++) begin
            c0 = 8'($urandom);
            c1 = 8'($urandom);
            flush();
            send_frame(c0, c1, 1'b0, NB, $urandom_range(0, NB - 2), $urandom_range(0, NB - 2),
                       $urandom_range(0, 3), f, l);
            idle(3);
            n_tests++;
            if (v_cyc.size() !== 1 || p_cyc.size() !== 0 || a_cyc.size() !== 0) begin
                n_fail++;
                $display("FAIL random_%0d_pulses: got valid %0d perr %0d abort %0d want 1 0 0",
                         i, v_cyc.size(), p_cyc.size(), a_cyc.size());
            end else if (v_cyc[0] !== l || v_b0[0] !== c0 || v_b1[0] !== c1) begin
                n_fail++;
                $display("FAIL random_%0d_data: got cyc %0d %h/%h want cyc %0d %h/%h",
                         i, v_cyc[0], v_b0[0], v_b1[0], l, c0, c1);
            end
            exp_b0 = c0; exp_b1 = c1;
        end
    endtask

    task automatic test_abort;
        int f, l, f2, l2;
        flush();
        send_frame(8'($urandom), 8'($urandom), 1'b0, 9, -1, -1, 0, f, l);
        send_frame(8'h01, 8'h80, 1'b0, NB, -1, -1, 0, f2, l2);
        idle(3);
        n_tests++;
        if (a_cyc.size() !== 1) begin
            n_fail++; $display("FAIL abort_count: got %0d want 1", a_cyc.size());
        end else if (a_cyc[0] !== f2 || a_out[0] !== {exp_b0, exp_b1}) begin
            n_fail++;
            $display("FAIL abort_pulse: got cyc %0d bytes %h want cyc %0d bytes %h",
                     a_cyc[0], a_out[0], f2, {exp_b0, exp_b1});
        end
        n_tests++;
        if (v_cyc.size() !== 1) begin
            n_fail++; $display("FAIL abort_valid_count: got %0d want 1", v_cyc.size());
        end else if (v_cyc[0] !== l2 || v_b0[0] !== 8'h01 || v_b1[0] !== 8'h80) begin
            n_fail++;
            $display("FAIL abort_data: got cyc %0d %h/%h want cyc %0d 01/80", v_cyc[0], v_b0[0], v_b1[0], l2);
        end
        exp_b0 = 8'h01; exp_b1 = 8'h80;
    endtask

    task automatic test_back_to_back;
        int f, l, f2, l2;
        flush();
        send_frame(8'hFF, 8'h00, 1'b0, NB, -1, -1, 0, f, l);
        send_frame(8'h00, 8'hFF, 1'b0, NB, -1, -1, 0, f2, l2);
        idle(3);
        n_tests++;
        if (v_cyc.size() !== 2 || a_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_count: got valid %0d abort %0d want 2 0", v_cyc.size(), a_cyc.size());
        end else begin
            n_tests++;
            if (v_cyc[1] - v_cyc[0] !== NB || v_cyc[1] !== l2) begin
                n_fail++; $display("FAIL b2b_gap: got %0d want %0d", v_cyc[1] - v_cyc[0], NB);
            end
            n_tests++;
            if ({v_b0[0], v_b1[0], v_b0[1], v_b1[1]} !== 32'hFF0000FF) begin
                n_fail++;
                $display("FAIL b2b_data: got %h want ff0000ff", {v_b0[0], v_b1[0], v_b0[1], v_b1[1]});
            end
        end
        exp_b0 = 8'h00; exp_b1 = 8'hFF;
    endtask

    task automatic test_reset_mid;
        int f, l;
        flush();
        send_frame(8'($urandom), 8'($urandom), 1'b0, 7, -1, -1, 0, f, l);
        @(negedge clk);
        n_tests++;
        if (u_if.busy !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy: got %b want 1", u_if.busy);
        end
        // Reset coincides with a sync beat: reset must win and produce no abort.
        u_if.b_valid = 1'b1; u_if.sync = 1'b1; u_if.b = 1'b1; rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({u_if.b0, u_if.b1, u_if.busy, u_if.b_out_valid, u_if.abort} !== 19'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h/%h busy %b valid %b abort %b want 00/00 0 0 0",
                     u_if.b0, u_if.b1, u_if.busy, u_if.b_out_valid, u_if.abort);
        end
        rst = 1'b0; u_if.b_valid = 1'b0; u_if.sync = 1'b0;
        send_frame(8'h5A, 8'hC3, 1'b0, NB, -1, -1, 0, f, l);
        idle(3);
        n_tests++;
        if (a_cyc.size() !== 0 || v_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL rstmid_pulses: got abort %0d valid %0d want 0 1", a_cyc.size(), v_cyc.size());
        end else if (v_cyc[0] !== l || v_b0[0] !== 8'h5A || v_b1[0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL rstmid_data: got cyc %0d %h/%h want cyc %0d 5A/C3", v_cyc[0], v_b0[0], v_b1[0], l);
        end
        exp_b0 = 8'h5A; exp_b1 = 8'hC3;
    endtask

`ifdef DEMUX_PARITY_EN
    task automatic test_parity;
        int f, l;
        flush();
        send_frame(8'hA5, 8'h3C, 1'b1, NB, -1, -1, 0, f, l);
        idle(3);
        n_tests++;
        if (p_cyc.size() !== 1 || v_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL parity_pulses: got perr %0d valid %0d want 1 0", p_cyc.size(), v_cyc.size());
        end else if (p_cyc[0] !== l) begin
            n_fail++; $display("FAIL parity_cycle: got %0d want %0d", p_cyc[0], l);
        end
        n_tests++;
        if (u_if.b0 !== exp_b0 || u_if.b1 !== exp_b1) begin
            n_fail++;
            $display("FAIL parity_hold: got %h/%h want %h/%h", u_if.b0, u_if.b1, exp_b0, exp_b1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef DEMUX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_frame.md
DEMUX_FRAME -- requirements
Module: demux_frame

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have port `clk`, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port `b`, input, 1 bit: time-multiplexed line carrying interleaved channel-0/channel-1 bits.
REQ-005 The block SHALL have port `b_valid`, input, 1 bit: `b` holds a beat this cycle.
REQ-006 The block SHALL have port `sync`, input, 1 bit: frame start; sampled only when `b_valid`=1.
REQ-007 The block SHALL have port `b0`, output, 8 bits: channel-0 byte, registered.
REQ-008 The block SHALL have port `b1`, output, 8 bits: channel-1 byte, registered.
REQ-009 The block SHALL have port `b_out_valid`, output, 1 bit: one-cycle pulse; `b0`/`b1` hold a new frame.
REQ-010 The block SHALL have port `abort`, output, 1 bit: one-cycle pulse; in-progress frame discarded.
REQ-011 The block SHALL have port `busy`, output, 1 bit: FSM is in RUN.
REQ-012 The block SHALL have port `parity_err`, output, 1 bit: one-cycle pulse; parity mismatch (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE and RUN, with a 5-bit beat counter `k`.
REQ-014 In IDLE, a beat with `sync`=1 SHALL be accepted as beat 0 and move the FSM to RUN with `k`=1; beats with `sync`=0 SHALL be ignored.
REQ-015 Beat `k` SHALL carry channel `k[0]` (even beats = ch0, odd beats = ch1), bit index `k>>1`, LSB first.
REQ-016 A frame SHALL be 16 data beats (N=16), or 17 beats when `DEMUX_PARITY_EN` is defined.
REQ-017 A cycle with `b_valid`=0 SHALL stall: `k` and the shift registers are held, with no timeout.
REQ-018 On acceptance of beat N-1: `b0`/`b1` SHALL update on the next edge, `b_out_valid` SHALL pulse in the following cycle (latency 1 cycle), and the FSM SHALL return to IDLE.
REQ-019 A `sync` beat arriving in the cycle immediately after the last beat SHALL start a new frame, giving zero dead cycles back-to-back.
REQ-020 `sync`=1 with `b_valid`=1 while in RUN SHALL pulse `abort` and restart the frame with that beat as beat 0; `b0`/`b1` SHALL be unchanged and `b_out_valid` SHALL NOT pulse.
REQ-021 `b0`/`b1` SHALL hold their last completed value until the next completed frame.
REQ-022 `busy` SHALL be 1 exactly while in RUN.

Reset
REQ-023 On `rst`=1 at a clock edge, the block SHALL set FSM=IDLE, `k`=0, shift registers=0, `b0`=`b1`=8'h00, and `b_out_valid`=`abort`=`parity_err`=`busy`=0.
REQ-024 Reset SHALL take priority over all inputs; reset mid-frame SHALL discard the frame with no `abort` pulse.

Configuration
REQ-025 The parity feature SHALL be controlled by macro `DEMUX_PARITY_EN`.
REQ-026 With `DEMUX_PARITY_EN` defined: beat 16 SHALL be an even-parity bit over all 16 data bits; on mismatch, `parity_err` SHALL pulse in the same cycle `b_out_valid` would, and `b_out_valid` SHALL be suppressed with `b0`/`b1` unchanged.
REQ-027 Without `DEMUX_PARITY_EN`: N=16 and `parity_err` SHALL be tied 0.

Verification
REQ-028 Frame test: send ch0=8'hA5, ch1=8'h3C interleaved LSB first, no stalls -> `b0`=A5, `b1`=3C, `b_out_valid` pulses 1 cycle after the last beat.
REQ-029 Stall test: the same frame with `b_valid`=0 for 3 cycles after beats 4 and 11 -> identical output, with valid delayed by 6 cycles.
REQ-030 Abort test: `sync` at beat 9, then a full frame ch0=8'h01, ch1=8'h80 -> one `abort` pulse, then `b0`=01, `b1`=80.
REQ-031 Back-to-back test: two frames (FF/00, then 00/FF) with no gap -> two valid pulses 16 cycles apart (17 with parity).
REQ-032 Reset test: assert `rst` at beat 7, then a new frame 8'h5A/8'hC3 -> all outputs reset, then the correct bytes and no `abort`.
REQ-033 Parity test (with `DEMUX_PARITY_EN`): 8'hA5/8'h3C with a wrong parity bit -> `parity_err` pulses, no `b_out_valid`, `b0`/`b1` hold prior values.
